// File: rtl/lfsr_pkg.sv
// ============================================================================
//  Module      : lfsr_pkg
//  Description : Shared definitions for the lfsr_gen family. Holds the
//                topology enum, the legal width range, and default
//                maximal-length feedback masks for widths 3..32 in both
//                Fibonacci and Galois form.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lfsr_pkg;

    typedef enum logic {
        LFSR_FIB = 1'b0,
        LFSR_GAL = 1'b1
    } lfsr_mode_e;

    localparam int LFSR_MIN_WIDTH = 3;
    localparam int LFSR_MAX_WIDTH = 32;

    // One-hot mask for a 1-based tap number.
    function automatic logic [31:0] tap_bit(input int k);
        return 32'd1 << (k - 1);
    endfunction

    // Maximal-length Fibonacci masks for a left-shifting register whose new
    // LSB is the parity of (q & mask). The MSB tap is always present.
    function automatic logic [31:0] lfsr_fib_taps(input int width);
        logic [31:0] m;
        m = '0;
        case (width)
            3:  m = tap_bit(3)  | tap_bit(2);
            4:  m = tap_bit(4)  | tap_bit(3);
            5:  m = tap_bit(5)  | tap_bit(3);
            6:  m = tap_bit(6)  | tap_bit(5);
            7:  m = tap_bit(7)  | tap_bit(6);
            8:  m = tap_bit(8)  | tap_bit(6)  | tap_bit(5) | tap_bit(4);
            9:  m = tap_bit(9)  | tap_bit(5);
            10: m = tap_bit(10) | tap_bit(7);
            11: m = tap_bit(11) | tap_bit(9);
            12: m = tap_bit(12) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
            13: m = tap_bit(13) | tap_bit(4)  | tap_bit(3) | tap_bit(1);
            14: m = tap_bit(14) | tap_bit(5)  | tap_bit(3) | tap_bit(1);
            15: m = tap_bit(15) | tap_bit(14);
            16: m = tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
            17: m = tap_bit(17) | tap_bit(14);
            18: m = tap_bit(18) | tap_bit(11);
            19: m = tap_bit(19) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
            20: m = tap_bit(20) | tap_bit(17);
            21: m = tap_bit(21) | tap_bit(19);
            22: m = tap_bit(22) | tap_bit(21);
            23: m = tap_bit(23) | tap_bit(18);
            24: m = tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
            25: m = tap_bit(25) | tap_bit(22);
            26: m = tap_bit(26) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
            27: m = tap_bit(27) | tap_bit(5)  | tap_bit(2) | tap_bit(1);
            28: m = tap_bit(28) | tap_bit(25);
            29: m = tap_bit(29) | tap_bit(27);
            30: m = tap_bit(30) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
            31: m = tap_bit(31) | tap_bit(28);
            32: m = tap_bit(32) | tap_bit(22) | tap_bit(2) | tap_bit(1);
            default: m = '0;
        endcase
        return m;
    endfunction

    // The Galois form of the same primitive polynomial: each non-MSB tap k
    // becomes mask bit k, and the constant term becomes bit 0. The MSB tap
    // is implied by the shifted-out bit, so it falls off the top.
    function automatic logic [31:0] lfsr_gal_taps(input int width);
        logic [31:0] f;
        logic [32:0] w_mask;
        f      = lfsr_fib_taps(width);
        w_mask = (33'd1 << width) - 33'd1;
        return ((f << 1) | 32'd1) & w_mask[31:0];
    endfunction

endpackage : lfsr_pkg

`default_nettype wire

// File: rtl/lfsr_gen_next.sv
// ============================================================================
//  Module      : lfsr_next
//  Description : Pure combinational one-step LFSR transition, usable by the
//                generator and by models/scoreboards alike.
//  Ports       : q      in  WIDTH  present state
//                q_next out WIDTH  state after one step
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 3,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(3'b101),
    parameter lfsr_mode_e       MODE  = LFSR_FIB
) (
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_next
);

    generate
        if (MODE == LFSR_FIB) begin : g_fib
            // Shift left, parity of the tapped bits enters at the LSB.
            assign q_next = {q[WIDTH-2:0], ^(q & TAPS)};
        end else begin : g_gal
            // Shift left; the bit falling out of the MSB folds into the taps.
            assign q_next = {q[WIDTH-2:0], 1'b0} ^ ({WIDTH{q[WIDTH-1]}} & TAPS);
        end
    endgenerate

endmodule : lfsr_next

`default_nettype wire

// File: rtl/lfsr_gen.sv
// ============================================================================
//  Module      : lfsr_gen
//  Description : Parametrised LFSR with seed load, step enable, period
//                measurement and all-zero lockup detection.
//  Ports       : clk      in  1      clock, rising edge
//                rst      in  1      asynchronous active-high reset
//                en       in  1      advance one step
//                load     in  1      load load_val (priority over en)
//                load_val in  WIDTH  value to load
//                q        out WIDTH  registered state
//                wrap     out 1      pulse when a step returns q to start
//                period   out WIDTH  steps in the last completed cycle
//                lockup   out 1      high while q == 0
//  Config      : LFSR_GEN_LOCKUP_RECOVER_EN - when defined, an en step taken
//                in the all-zero state reloads SEED instead of staying stuck.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 3,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(3'b101),
    parameter lfsr_mode_e       MODE  = LFSR_FIB,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(3'b100)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic [WIDTH-1:0] period,
    output logic             lockup
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

`ifdef LFSR_GEN_LOCKUP_RECOVER_EN
    localparam bit RECOVER_EN = 1'b1;
`else
    localparam bit RECOVER_EN = 1'b0;
`endif

    generate
        if (WIDTH < LFSR_MIN_WIDTH || WIDTH > LFSR_MAX_WIDTH) begin : g_bad_width
            $error("lfsr_gen: WIDTH %0d outside %0d..%0d", WIDTH, LFSR_MIN_WIDTH, LFSR_MAX_WIDTH);
        end
        if (SEED == '0) begin : g_bad_seed
            $error("lfsr_gen: SEED must be non-zero");
        end
    endgenerate

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] start;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_inc;
    logic             recover;
    logic             hit;

    lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .MODE  (MODE)
    ) u_next (
        .q      (q),
        .q_next (q_next)
    );

    // Saturating increment: a counter stuck at all-ones means "at least this
    // many steps", never a misleading small value after overflow.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + WIDTH'(1);
    assign recover = RECOVER_EN && (q == '0);
    assign hit     = (q_next == start);
    assign lockup  = (q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q      <= SEED;
            start  <= SEED;
            cnt    <= '0;
            period <= '0;
            wrap   <= 1'b0;
        end else if (load) begin
            q     <= load_val;
            start <= load_val;
            cnt   <= '0;
            wrap  <= 1'b0;
        end else if (en) begin
            if (recover) begin
                // Restart from the seed as a fresh sequence; not a wrap.
                q     <= SEED;
                start <= SEED;
                cnt   <= '0;
                wrap  <= 1'b0;
            end else begin
                q <= q_next;
                if (hit) begin
                    wrap   <= 1'b1;
                    period <= cnt_inc;
                    cnt    <= '0;
                end else begin
                    wrap <= 1'b0;
                    cnt  <= cnt_inc;
                end
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule : lfsr_gen

`default_nettype wire
